// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with per-register pending scoreboard and W->D bypass
//   clk_i/rst_ni               clock, synchronous active-low reset
//   rs1_d_i/rs2_d_i            Decode source indices
//   rd1_d_o/rd2_d_o            operand data (combinational)
//   busy1_d_o/busy2_d_o        operand still owed by an older instruction
//   issue_d_i/rd_issue_d_i     Decode marks a destination as in flight
//   reg_write_w_i/rd_w_i/result_w_i  Writeback write port
//   flush_i                    squash all in-flight writes
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      rs1_d_i,
    input  logic [4:0]      rs2_d_i,
    output logic [XLEN-1:0] rd1_d_o,
    output logic [XLEN-1:0] rd2_d_o,
    output logic            busy1_d_o,
    output logic            busy2_d_o,
    input  logic            issue_d_i,
    input  logic [4:0]      rd_issue_d_i,
    input  logic            reg_write_w_i,
    input  logic [4:0]      rd_w_i,
    input  logic [XLEN-1:0] result_w_i,
    input  logic            flush_i
);
    logic [XLEN-1:0] regs_q [32];
    logic [31:0]     pend_q, pend_d;
    logic            we, hit1, hit2;
    assign we   = reg_write_w_i && rd_w_i != 5'd0;
    assign hit1 = BYPASS && we && rd_w_i == rs1_d_i;
    assign hit2 = BYPASS && we && rd_w_i == rs2_d_i;
    assign rd1_d_o   = rs1_d_i == 5'd0 ? '0 : hit1 ? result_w_i : regs_q[rs1_d_i];
    assign rd2_d_o   = rs2_d_i == 5'd0 ? '0 : hit2 ? result_w_i : regs_q[rs2_d_i];
    // bit 0 of the pending vector is held at zero, so x0 is never busy
    assign busy1_d_o = pend_q[rs1_d_i] && !hit1;
    assign busy2_d_o = pend_q[rs2_d_i] && !hit2;
    // issue is applied after the W clear so the younger instruction keeps ownership
    always_comb begin
        pend_d = pend_q;
        if (we) pend_d[rd_w_i] = 1'b0;
        if (issue_d_i) pend_d[rd_issue_d_i] = 1'b1;
        if (flush_i) pend_d = '0;
        pend_d[0] = 1'b0;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (we) regs_q[rd_w_i] <= result_w_i;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized check of regfile_sb (both bypass variants) against a behavioural model
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst_ni, issue, we, flush;
    logic [4:0]  rs1, rs2, rdi, rdw;
    logic [31:0] res;
    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_bz1, b_bz2, n_bz1, n_bz2;
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .BYPASS(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_ni), .rs1_d_i(rs1), .rs2_d_i(rs2),
        .rd1_d_o(b_rd1), .rd2_d_o(b_rd2), .busy1_d_o(b_bz1), .busy2_d_o(b_bz2),
        .issue_d_i(issue), .rd_issue_d_i(rdi), .reg_write_w_i(we), .rd_w_i(rdw),
        .result_w_i(res), .flush_i(flush));

    regfile_sb #(.XLEN(32), .BYPASS(1'b0)) u_n (
        .clk_i(clk), .rst_ni(rst_ni), .rs1_d_i(rs1), .rs2_d_i(rs2),
        .rd1_d_o(n_rd1), .rd2_d_o(n_rd2), .busy1_d_o(n_bz1), .busy2_d_o(n_bz2),
        .issue_d_i(issue), .rd_issue_d_i(rdi), .reg_write_w_i(we), .rd_w_i(rdw),
        .result_w_i(res), .flush_i(flush));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] rs, input bit byp);
        if (rs == 0) return 32'd0;
        if (byp && we && rdw == rs) return res;
        return m_regs[rs];
    endfunction

    function automatic logic [31:0] exp_bz(input logic [4:0] rs, input bit byp);
        return {31'd0, rs != 0 && m_pend[rs] && !(byp && we && rdw == rs)};
    endfunction

    task automatic compare_all();
        chk("b_rd1", b_rd1, exp_rd(rs1, 1));
        chk("b_rd2", b_rd2, exp_rd(rs2, 1));
        chk("b_busy1", {31'd0, b_bz1}, exp_bz(rs1, 1));
        chk("b_busy2", {31'd0, b_bz2}, exp_bz(rs2, 1));
        chk("n_rd1", n_rd1, exp_rd(rs1, 0));
        chk("n_rd2", n_rd2, exp_rd(rs2, 0));
        chk("n_busy1", {31'd0, n_bz1}, exp_bz(rs1, 0));
        chk("n_busy2", {31'd0, n_bz2}, exp_bz(rs2, 0));
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0;
                m_pend[i] = 0;
            end
        end else begin
            if (we && rdw != 0) m_regs[rdw] = res;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_pend[i] = 0;
            end else begin
                if (we) m_pend[rdw] = 0;
                if (issue && rdi != 0) m_pend[rdi] = 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst_ni = 1; issue = 0; we = 0; flush = 0;
        rdi = 0; rdw = 0; res = 0;
    endtask

    initial begin
        idle(); rs1 = 0; rs2 = 0;
        rst_ni = 0;
        adv();
        rst_ni = 1; rs1 = 5; rs2 = 31;
        settle();
        chk("rst_rd1", b_rd1, 32'd0);
        chk("rst_rd2", b_rd2, 32'd0);
        chk("rst_busy", {30'd0, b_bz1, b_bz2}, 32'd0);
        adv();
        we = 1; rdw = 7; res = 32'hDEADBEEF;
        settle(); adv();
        idle(); rs1 = 7;
        settle();
        chk("wr_x7_b", b_rd1, 32'hDEADBEEF);
        chk("wr_x7_n", n_rd1, 32'hDEADBEEF);
        we = 1; rdw = 0; res = 32'h1234; rs2 = 0;
        settle();
        chk("wr_x0_same", b_rd2, 32'd0);
        adv();
        idle();
        settle();
        chk("wr_x0_after", b_rd2, 32'd0);
        adv();
        issue = 1; rdi = 9;
        settle(); adv();
        idle(); we = 1; rdw = 9; res = 32'hA5A5A5A5; rs1 = 9;
        settle();
        chk("byp_rd1", b_rd1, 32'hA5A5A5A5);
        chk("byp_busy1", {31'd0, b_bz1}, 32'd0);
        chk("nobyp_rd1", n_rd1, 32'd0);
        chk("nobyp_busy1", {31'd0, n_bz1}, 32'd1);
        adv();
        idle(); issue = 1; rdi = 3;
        settle(); adv();
        idle(); rs2 = 3;
        settle();
        chk("sb_busy2", {31'd0, b_bz2}, 32'd1);
        we = 1; rdw = 3; res = 32'h55;
        #1;
        chk("sb_ret_busy2", {31'd0, b_bz2}, 32'd0);
        chk("sb_ret_rd2", b_rd2, 32'h55);
        adv();
        idle();
        settle();
        chk("sb_after_busy2", {31'd0, b_bz2}, 32'd0);
        chk("sb_after_rd2", b_rd2, 32'h55);
        adv();
        issue = 1; rdi = 3; we = 1; rdw = 3; res = 32'h77;
        settle(); adv();
        idle();
        settle();
        chk("iss_ret_busy", {31'd0, b_bz2}, 32'd1);
        chk("iss_ret_data", b_rd2, 32'h77);
        adv();
        issue = 1; rdi = 4;
        settle(); adv();
        rdi = 10;
        settle(); adv();
        flush = 1; rdi = 12;
        settle(); adv();
        idle(); rs1 = 4; rs2 = 10;
        settle();
        chk("flush_x4", {31'd0, b_bz1}, 32'd0);
        chk("flush_x10", {31'd0, b_bz2}, 32'd0);
        rs1 = 12;
        #1;
        chk("flush_x12", {31'd0, b_bz1}, 32'd0);
        adv();
        for (int k = 0; k < 3000; k++) begin
            rst_ni = ($urandom % 200) != 0;
            issue  = ($urandom % 10) < 3;
            we     = ($urandom % 2) == 1;
            flush  = ($urandom % 40) == 0;
            rdi    = 5'(($urandom % 2) ? $urandom % 8 : $urandom % 32);
            rdw    = 5'(($urandom % 2) ? $urandom % 8 : $urandom % 32);
            rs1    = 5'(($urandom % 2) ? $urandom % 8 : $urandom % 32);
            rs2    = 5'(($urandom % 2) ? $urandom % 8 : $urandom % 32);
            res    = $urandom;
            settle();
            adv();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
